// File: rtl/cal_norm_q_if.sv
// Handshake and data bundle between the residual stage, cal_norm_q and its consumer.
// slave is the normalizer's view; master is the surrounding producer/consumer view.
interface cal_norm_q_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [27:0] v1_real;
  logic signed [27:0] v1_imag;
  logic signed [27:0] v2_real;
  logic signed [27:0] v2_imag;
  logic               out_valid;
  logic               out_ready;
  logic signed [27:0] R22;
  logic signed [27:0] Q1_real;
  logic signed [27:0] Q1_imag;
  logic signed [27:0] Q2_real;
  logic signed [27:0] Q2_imag;
  logic               zero_norm;

  modport slave (
    input  in_valid, v1_real, v1_imag, v2_real, v2_imag, out_ready,
    output in_ready, out_valid, R22, Q1_real, Q1_imag, Q2_real, Q2_imag, zero_norm
  );

  modport master (
    output in_valid, v1_real, v1_imag, v2_real, v2_imag, out_ready,
    input  in_ready, out_valid, R22, Q1_real, Q1_imag, Q2_real, Q2_imag, zero_norm
  );
endinterface

// File: rtl/cal_norm_q.sv
// Normalizes residual v: R22 = floor(sqrt(|v|^2)), Q = trunc(v*1000/R22); fixed 182-cycle latency.
// Single transaction in flight: in_ready only in IDLE, results held in DONE until out_ready.
module cal_norm_q (
  input logic         clk,
  input logic         rst_n,
  cal_norm_q_if.slave io
);

  typedef enum logic [2:0] {IDLE, SQ, SQRT, DIV, DONE} state_t;

  state_t             state;
  logic        [27:0] vin [4];
  logic        [57:0] rad;
  logic        [31:0] srem;
  logic        [28:0] root;
  logic        [5:0]  cnt;
  logic        [1:0]  comp;
  logic        [37:0] dq;
  logic        [29:0] drem;
  logic signed [27:0] res [3];

  logic signed [55:0] p0, p1, p2, p3;
  logic        [57:0] norm_sq_c;
  logic        [31:0] srem_sh, strial;
  logic               sge;
  logic        [29:0] drem_sh, dsor;
  logic               dge;
  logic        [37:0] q_next;
  logic        [27:0] mag;
  logic signed [27:0] quo;
  logic        [1:0]  next_comp;

  function automatic logic [37:0] scaled_abs(input logic [27:0] x);
    logic [27:0] a;
    a = x[27] ? (~x + 28'd1) : x;
    return 38'(a) * 38'd1000;
  endfunction

  assign p0 = $signed(vin[0]) * $signed(vin[0]);
  assign p1 = $signed(vin[1]) * $signed(vin[1]);
  assign p2 = $signed(vin[2]) * $signed(vin[2]);
  assign p3 = $signed(vin[3]) * $signed(vin[3]);
  assign norm_sq_c = 58'($unsigned(p0)) + 58'($unsigned(p1))
                   + 58'($unsigned(p2)) + 58'($unsigned(p3));

  // Digit-by-digit root: bring down two radicand bits, try appending a 1 to the root.
  assign srem_sh = 32'({srem, rad[57:56]});
  assign strial  = {1'b0, root, 2'b01};
  assign sge     = (srem_sh >= strial);

  // Restoring division: dividend bits shift out of dq's MSB while quotient bits shift in.
  assign drem_sh   = 30'({drem, dq[37]});
  assign dsor      = {1'b0, root};
  assign dge       = (drem_sh >= dsor);
  assign q_next    = {dq[36:0], dge};
  assign mag       = q_next[27:0];
  assign quo       = (root == 29'd0) ? 28'sd0
                   : (vin[comp][27] ? -$signed(mag) : $signed(mag));
  assign next_comp = comp + 2'd1;

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int i = 0; i < 4; i++) vin[i] <= '0;
      for (int i = 0; i < 3; i++) res[i] <= '0;
      rad     <= '0;
      srem    <= '0;
      root    <= '0;
      cnt     <= '0;
      comp    <= '0;
      dq      <= '0;
      drem    <= '0;
      io.R22       <= '0;
      io.Q1_real   <= '0;
      io.Q1_imag   <= '0;
      io.Q2_real   <= '0;
      io.Q2_imag   <= '0;
      io.zero_norm <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          vin[0] <= io.v1_real;
          vin[1] <= io.v1_imag;
          vin[2] <= io.v2_real;
          vin[3] <= io.v2_imag;
          state  <= SQ;
        end
        SQ: begin
          rad   <= norm_sq_c;
          srem  <= '0;
          root  <= '0;
          cnt   <= '0;
          state <= SQRT;
        end
        SQRT: begin
          rad  <= {rad[55:0], 2'b00};
          srem <= sge ? (srem_sh - strial) : srem_sh;
          root <= {root[27:0], sge};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd28) begin
            cnt   <= '0;
            comp  <= '0;
            drem  <= '0;
            dq    <= scaled_abs(vin[0]);
            state <= DIV;
          end
        end
        DIV: begin
          drem <= dge ? (drem_sh - dsor) : drem_sh;
          dq   <= q_next;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd37) begin
            cnt  <= '0;
            drem <= '0;
            dq   <= scaled_abs(vin[next_comp]);
            if (comp == 2'd3) begin
              io.R22       <= $signed(root[27:0]);
              io.Q1_real   <= res[0];
              io.Q1_imag   <= res[1];
              io.Q2_real   <= res[2];
              io.Q2_imag   <= quo;
              io.zero_norm <= (root == 29'd0);
              state        <= DONE;
            end else begin
              res[comp] <= quo;
              comp      <= next_comp;
            end
          end
        end
        DONE: if (io.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cal_norm_q.sv
// Scoreboard bench for cal_norm_q: driver queues hand-computed results at acceptance,
// monitor pops and compares on every output handshake, plus latency, hold and reset-abort checks.
module tb_cal_norm_q;

  typedef struct {
    longint r22;
    longint q0, q1, q2, q3;
    longint zn;
    int     acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc = 0;
  int     nchk = 0;
  int     nerr = 0;
  exp_t   sb[$];
  logic   prev_vld = 1'b0;

  cal_norm_q_if itf ();

  cal_norm_q dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (itf.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, full result compare on handshake.
  always @(negedge clk) begin
    if (rst_n && itf.out_valid) begin
      if (!prev_vld) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - sb[0].acc, 182);
      end
      if (itf.out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("R22",       itf.R22,       e.r22);
        chk("Q1_real",   itf.Q1_real,   e.q0);
        chk("Q1_imag",   itf.Q1_imag,   e.q1);
        chk("Q2_real",   itf.Q2_real,   e.q2);
        chk("Q2_imag",   itf.Q2_imag,   e.q3);
        chk("zero_norm", itf.zero_norm, e.zn);
      end
    end
    prev_vld = rst_n && itf.out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int a, input int b, input int c, input int d, input bit push,
                      input longint r22, input longint q0, input longint q1,
                      input longint q2, input longint q3, input longint zn);
    int   n;
    exp_t e;
    n = 0;
    while (!itf.in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!itf.in_ready) chk("in_ready_timeout", itf.in_ready, 1);
    itf.v1_real  = 28'(a);
    itf.v1_imag  = 28'(b);
    itf.v2_real  = 28'(c);
    itf.v2_imag  = 28'(d);
    itf.in_valid = 1'b1;
    @(posedge clk); #1;
    itf.in_valid = 1'b0;
    if (push) begin
      e.r22 = r22; e.q0 = q0; e.q1 = q1; e.q2 = q2; e.q3 = q3; e.zn = zn; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  initial begin
    int bad;
    int n;
    itf.in_valid  = 1'b0;
    itf.out_ready = 1'b1;
    itf.v1_real   = '0;
    itf.v1_imag   = '0;
    itf.v2_real   = '0;
    itf.v2_imag   = '0;

    #12;
    chk("rst_out_valid", itf.out_valid, 0);
    chk("rst_R22",       itf.R22,       0);
    chk("rst_Q1_real",   itf.Q1_real,   0);
    chk("rst_zero_norm", itf.zero_norm, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", itf.in_ready, 1);

    send(600, 0, 0, 800, 1,   1000, 600, 0, 0, 800, 0);
    send(-300, 400, 0, 0, 1,  500, -600, 800, 0, 0, 0);
    send(1, 1, 1, -1, 1,      2, 500, 500, 500, -500, 0);
    send(1, 1, 0, 0, 1,       1, 1000, 1000, 0, 0, 0);
    send(0, 0, 0, 0, 1,       0, 0, 0, 0, 0, 1);
    send(134217727, 0, 0, 0, 1, 134217727, 1000, 0, 0, 0, 0);
    send(-2, 3, 0, 0, 1,      3, -666, 1000, 0, 0, 0);

    // Hold the result in DONE for 50 cycles.
    n = 0;
    while (!itf.in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    itf.out_ready = 1'b0;
    send(-600, 0, 0, -800, 1, 1000, -600, 0, 0, -800, 0);
    n = 0;
    while (!itf.out_valid && n < 400) begin @(posedge clk); #1; n++; end
    chk("hold_reach_done", itf.out_valid, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (itf.out_valid !== 1'b1 || itf.in_ready !== 1'b0 || itf.R22 !== 28'sd1000 ||
          itf.Q1_real !== -28'sd600 || itf.Q1_imag !== 28'sd0 || itf.Q2_real !== 28'sd0 ||
          itf.Q2_imag !== -28'sd800 || itf.zero_norm !== 1'b0)
        bad++;
    end
    chk("hold_stable_bad_cycles", bad, 0);
    @(posedge clk); #1;
    itf.out_ready = 1'b1;

    // Abort a transaction mid-SQRT with an asynchronous reset.
    send(600, 0, 0, 800, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", itf.out_valid, 0);
    chk("abort_R22",       itf.R22,       0);
    chk("abort_Q_or",      itf.Q1_real | itf.Q1_imag | itf.Q2_real | itf.Q2_imag, 0);
    chk("abort_zero_norm", itf.zero_norm, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_in_ready", itf.in_ready, 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (itf.out_valid !== 1'b0) bad++;
    end
    chk("abort_no_output", bad, 0);
    @(posedge clk); #1;

    send(3, 4, 0, 0, 1, 5, 600, 800, 0, 0, 0);

    n = 0;
    while (sb.size() != 0 && n < 1000) begin @(posedge clk); n++; end
    @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
